uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised UART transmitter combining the transmit control FSM, baud-period counter, bit counter and shift register in one block. Replaces the fixed 2-bit-state load/start controller. Adds a valid/ready byte handshake, configurable data width, runtime parity and stop-bit selection, and gap-free back-to-back frames. Sits between the host-side byte source and the tx pin.

Parameters:
DATA_W, 8, data bits per frame (5..9).
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
CNT_W, $clog2(CLKS_PER_BIT), baud counter width (derived; do not override).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  DATA_W  byte to send, sampled on accept
tx_valid  input  1  host has data
tx_ready  output  1  engine accepts tx_data this cycle when tx_valid=1
parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); sampled on accept
stop2  input  1  1 = two stop bits, 0 = one; sampled on accept
tx_serial  output  1  serial line, idle high, registered
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of final stop bit

Behaviour:
- Reset (reset=0, async): state IDLE, tx_serial=1, tx_ready=1, busy=0, done=0, counters and shift register cleared. Reset mid-frame aborts the frame: line goes high immediately, no done pulse, and the aborted byte is dropped.
- Accept = tx_valid & tx_ready. On accept: latch tx_data, parity_mode and stop2. Next cycle: state START, tx_serial=0, busy=1.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- Each state bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry. bit_end = (cnt == CLKS_PER_BIT-1).
- DATA: LSB first. The shift register shifts right at bit_end. The bit counter runs 0..DATA_W-1, and DATA exits at bit_end of bit DATA_W-1.
- PARITY: entered only if the latched mode is 01 or 10. Even parity bit = ^data; odd parity bit = ~^data, computed over the latched byte.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT cycles if stop2.
- Frame length = (1 + DATA_W + P + S) * CLKS_PER_BIT cycles, where P = 0 or 1 and S = 1 or 2.
- tx_ready is asserted in IDLE and in the final cycle of the last stop bit.
  - Accept in that final cycle goes directly to START: zero idle cycles between frames.
  - done still pulses in that cycle.
- tx_ready is low in all other cycles. tx_valid while not ready is ignored; the host holds the data.
- done=1 only in the final cycle of the last stop bit. busy=1 from START entry through that same cycle.
- Config inputs changing mid-frame have no effect on the current frame.
- tx_serial is driven from a flop, so there are no combinational glitches on the pin.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - typedef enum logic [1:0] parity_t {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD}
- Sub-module uart_baud_cnt (param CLKS_PER_BIT):
  - inputs: clk, reset, clear, en
  - output: bit_end
  - instantiated once. The FSM, bit counter, stop counter and shift register stay in uart_tx_engine.

Test Plan:
Bench uses DATA_W=8, CLKS_PER_BIT=4.
- Reset idle: no tx_valid for 50 cycles after reset release -> tx_serial=1, tx_ready=1, busy=0, done never pulses.
- Basic frame: send 0x55, parity 00, stop2=0 -> 40-cycle frame. Bits sampled mid-bit read 0,1,0,1,0,1,0,1,0,1. done pulses at cycle 40 after the accept cycle.
- Parity: send 0xA7 with parity 01 -> parity bit 1. Send 0xA7 with parity 10 -> parity bit 0. Frame 44 cycles. Mode 11 -> 40-cycle frame, no parity bit.
- Two stop bits with back-to-back: tx_valid held high with 0x01 then 0x80, stop2=1 -> each frame 44 cycles; second start bit follows the final stop cycle with no idle gap; done pulses twice; tx_ready high only in IDLE and the final stop cycles.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF -> tx_serial=1 the same cycle (async), busy=0, no done. A new frame after release transmits correctly.
- Config change mid-frame: toggle parity_mode and stop2 during DATA -> the current frame uses the values latched at accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: FSM states, parity modes and a parity helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_t;

   // Only even and odd insert a parity bit; the reserved code behaves as none.
   function automatic logic has_parity(input parity_t mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of a bit.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic bit_end
);

   logic [CNT_W-1:0] cnt_q;

   assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: valid/ready byte intake, optional parity, one or two stop bits,
// and gap-free back-to-back frames with a registered serial output.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              tx_serial,
   output logic              busy,
   output logic              done
);

   localparam int unsigned BIT_W = $clog2(DATA_W);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic              par_en_q, par_bit_q, stop2_q;
   logic              tx_serial_q, tx_serial_d;
   logic              accept, bit_end, last_bit, last_stop, frame_end;

   assign accept    = tx_valid & tx_ready;
   assign last_bit  = (bit_cnt_q == BIT_W'(DATA_W - 1));
   assign last_stop = !stop2_q || stop_cnt_q;
   assign frame_end = (state_q == STOP) && bit_end && last_stop;

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_d != state_q),
      .en      (state_q != IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = START;
         START:   if (bit_end) state_d = DATA;
         DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
         PARITY:  if (bit_end) state_d = STOP;
         STOP:    if (frame_end) state_d = accept ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_ready = (state_q == IDLE) || frame_end;
      done     = frame_end;
      busy     = (state_q != IDLE);
   end

   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      if (accept) begin
         shift_d    = tx_data;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
      end else if (bit_end && state_q == DATA) begin
         shift_d   = shift_q >> 1;
         bit_cnt_d = bit_cnt_q + 1'b1;
      end else if (bit_end && state_q == STOP) begin
         stop_cnt_d = ~stop_cnt_q;
      end
      // Pin value is computed from next state so the flop presents it on state entry.
      unique case (state_d)
         START:   tx_serial_d = 1'b0;
         DATA:    tx_serial_d = shift_d[0];
         PARITY:  tx_serial_d = par_bit_q;
         default: tx_serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         par_en_q    <= 1'b0;
         par_bit_q   <= 1'b0;
         stop2_q     <= 1'b0;
         tx_serial_q <= 1'b1;
      end else begin
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_serial_q <= tx_serial_d;
         if (accept) begin
            par_en_q  <= has_parity(parity_t'(parity_mode));
            par_bit_q <= (parity_t'(parity_mode) == PAR_ODD) ? ~^tx_data : ^tx_data;
            stop2_q   <= stop2;
         end
      end
   end

   assign tx_serial = tx_serial_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: vector table, back-to-back, reset abort,
// config change and randomized frames against a bit-list reference model.
module tb_uart_tx_engine;

   localparam int DW  = 8;
   localparam int CPB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic [1:0]    parity_mode = 2'b00;
   logic          stop2 = 1'b0;
   logic          tx_ready, tx_serial, busy, done;

   uart_tx_engine #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx_serial   (tx_serial),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    pm;
      logic          s2;
   } frame_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    pm;
      logic          s2;
      int            exp_len;
      logic          has_par;
      logic          exp_par;
   } vec_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   logic   exp_bits[$];
   logic   got_bits[$];
   int     done_k;
   frame_t seq[$];
   vec_t   vecs[5];

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame as a list of line levels, one entry per serial bit.
   function automatic void build(input frame_t f);
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_bits.push_back(f.data[i]);
      if (f.pm == 2'b01) exp_bits.push_back(^f.data);
      if (f.pm == 2'b10) exp_bits.push_back(~^f.data);
      exp_bits.push_back(1'b1);
      if (f.s2) exp_bits.push_back(1'b1);
   endfunction

   task automatic check_idle(input string name);
      chk({name, "_serial"}, tx_serial, 1'b1);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_ready"}, tx_ready, 1'b1);
      chk({name, "_done"}, done, 1'b0);
   endtask

   task automatic send_seq(input bit b2b, input bit toggle);
      int guard;
      int len;
      @(negedge clk);
      tx_data     = seq[0].data;
      parity_mode = seq[0].pm;
      stop2       = seq[0].s2;
      tx_valid    = 1'b1;
      guard = 0;
      while (!tx_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!tx_ready) begin
         chk("accept_timeout", tx_ready, 1'b1);
         tx_valid = 1'b0;
         return;
      end
      for (int i = 0; i < seq.size(); i++) begin
         build(seq[i]);
         len = exp_bits.size() * CPB;
         got_bits.delete();
         done_k = 0;
         for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk("tx_serial", tx_serial, exp_bits[(k - 1) / CPB]);
            chk("busy", busy, 1'b1);
            chk("done", done, k == len);
            chk("tx_ready", tx_ready, k == len);
            if (done && done_k == 0) done_k = k;
            if ((k - 1) % CPB == CPB / 2) got_bits.push_back(tx_serial);
            if (k == 1) begin
               if (b2b && i + 1 < seq.size()) begin
                  tx_data     = seq[i + 1].data;
                  parity_mode = seq[i + 1].pm;
                  stop2       = seq[i + 1].s2;
               end else begin
                  tx_valid = 1'b0;
               end
            end
            if (toggle && k == 3 * CPB) begin
               parity_mode = ~parity_mode;
               stop2       = ~stop2;
            end
         end
      end
      @(negedge clk);
      check_idle("post_frame");
   endtask

   initial begin
      vecs[0] = '{data: 8'h55, pm: 2'b00, s2: 1'b0, exp_len: 40, has_par: 1'b0, exp_par: 1'b0};
      vecs[1] = '{data: 8'hA7, pm: 2'b01, s2: 1'b0, exp_len: 44, has_par: 1'b1, exp_par: 1'b1};
      vecs[2] = '{data: 8'hA7, pm: 2'b10, s2: 1'b0, exp_len: 44, has_par: 1'b1, exp_par: 1'b0};
      vecs[3] = '{data: 8'hA7, pm: 2'b11, s2: 1'b0, exp_len: 40, has_par: 1'b0, exp_par: 1'b0};
      vecs[4] = '{data: 8'h3C, pm: 2'b01, s2: 1'b1, exp_len: 48, has_par: 1'b1, exp_par: 1'b0};

      repeat (3) @(negedge clk);
      check_idle("in_reset");
      reset = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         check_idle("idle");
      end

      for (int v = 0; v < 5; v++) begin
         seq.delete();
         seq.push_back('{data: vecs[v].data, pm: vecs[v].pm, s2: vecs[v].s2});
         send_seq(1'b0, 1'b0);
         chk_int("frame_len", done_k, vecs[v].exp_len);
         if (vecs[v].has_par) chk("parity_bit", got_bits[9], vecs[v].exp_par);
         if (v == 0) begin
            for (int j = 0; j < 10; j++) chk("pattern_55", got_bits[j], 1'(j % 2));
         end
      end

      // Back-to-back with two stop bits: no idle gap between frames.
      seq.delete();
      seq.push_back('{data: 8'h01, pm: 2'b00, s2: 1'b1});
      seq.push_back('{data: 8'h80, pm: 2'b00, s2: 1'b1});
      send_seq(1'b1, 1'b0);
      chk_int("b2b_len", done_k, 44);

      // Reset during DATA bit 3 of 0xFF.
      @(negedge clk);
      tx_data = 8'hFF; parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("pre_abort_busy", busy, 1'b1);
      chk("pre_abort_serial", tx_serial, 1'b1);
      #1 reset = 1'b0;
      #1;
      check_idle("abort");
      repeat (3) begin
         @(negedge clk);
         check_idle("abort_hold");
      end
      reset = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_idle("abort_release");
      end

      // Config inputs flipped during DATA must not affect the frame.
      seq.delete();
      seq.push_back('{data: 8'h3C, pm: 2'b01, s2: 1'b0});
      send_seq(1'b0, 1'b1);
      chk_int("cfg_len", done_k, 44);
      chk("cfg_parity", got_bits[9], 1'b0);

      for (int r = 0; r < 40; r++) begin
         bit b2b;
         int n;
         b2b = 1'($urandom_range(0, 1));
         n   = b2b ? int'($urandom_range(2, 3)) : 1;
         seq.delete();
         for (int f = 0; f < n; f++) begin
            seq.push_back('{data: 8'($urandom), pm: 2'($urandom_range(0, 3)),
                            s2: 1'($urandom_range(0, 1))});
         end
         send_seq(b2b, !b2b && ($urandom_range(0, 1) == 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
